// File: rtl/time_adjust_ctrl.sv
// Time-setting field editor for the digital clock.
// Snapshots the running time on entry to adjust mode, lets the user step
// each BCD field up/down, blinks the selected field and emits a one-cycle
// commit pulse carrying the edited time when adjust mode is released.
module time_adjust_ctrl #(
  parameter int unsigned NUM_FIELDS   = 3,
  parameter int unsigned FIELD0_MAX   = 23,
  parameter int unsigned FIELDN_MAX   = 59,
  parameter int unsigned BLINK_CYCLES = 25000000,
  localparam int unsigned SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    adj_en,
  input  logic                    set,
  input  logic                    inc,
  input  logic                    dec,
  input  logic [8*NUM_FIELDS-1:0] cur_time,
  output logic [8*NUM_FIELDS-1:0] time_out,
  output logic [NUM_FIELDS-1:0]   blank,
  output logic [SEL_W-1:0]        field_sel,
  output logic                    editing,
  output logic                    commit
);

  localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_FIELDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT,
    ST_COMMIT
  } state_t;

  state_t                  state_q, state_d;
  logic [8*NUM_FIELDS-1:0] time_q, time_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_on_q, blink_on_d;
  logic                    set_prev_q, set_prev_d;
  logic                    inc_prev_q, inc_prev_d;
  logic                    dec_prev_q, dec_prev_d;

  logic set_edge, inc_edge, dec_edge, action;

  function automatic int unsigned field_max(input int unsigned idx);
    return (idx == 0) ? FIELD0_MAX : FIELDN_MAX;
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int unsigned bcd_value(input logic [7:0] b);
    return 32'(b[7:4]) * 32'd10 + 32'(b[3:0]);
  endfunction

  // Illegal digits or out-of-range values in the snapshot load as zero.
  function automatic logic [7:0] sanitize(input logic [7:0] b, input int unsigned max);
    if ((b[7:4] > 4'd9) || (b[3:0] > 4'd9) || (bcd_value(b) > max)) begin
      return 8'h00;
    end
    return b;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] b, input int unsigned max);
    if (bcd_value(b) >= max) begin
      return 8'h00;
    end
    if (b[3:0] == 4'd9) begin
      return {b[7:4] + 4'd1, 4'd0};
    end
    return {b[7:4], b[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] b, input int unsigned max);
    if (b == 8'h00) begin
      return to_bcd(max);
    end
    if (b[3:0] == 4'd0) begin
      return {b[7:4] - 4'd1, 4'd9};
    end
    return {b[7:4], b[3:0] - 4'd1};
  endfunction

  // Next-state, edit arithmetic, blink timing and decoded outputs.
  always_comb begin
    state_d     = state_q;
    time_d      = time_q;
    sel_d       = sel_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    set_prev_d  = set;
    inc_prev_d  = inc;
    dec_prev_d  = dec;
    editing     = 1'b0;
    commit      = 1'b0;
    blank       = '0;

    set_edge = set & ~set_prev_q;
    inc_edge = inc & ~inc_prev_q;
    dec_edge = dec & ~dec_prev_q;
    action   = set_edge | inc_edge | dec_edge;

    case (state_q)
      ST_IDLE: begin
        time_d      = cur_time;
        sel_d       = '0;
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if (adj_en) begin
          state_d = ST_EDIT;
          for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            time_d[8*(NUM_FIELDS-i)-1 -: 8] =
              sanitize(cur_time[8*(NUM_FIELDS-i)-1 -: 8], field_max(i));
          end
        end
      end

      ST_EDIT: begin
        editing        = 1'b1;
        blank[sel_q]   = ~blink_on_q;
        if (!adj_en) begin
          // Button edges seen on the exit cycle are dropped on purpose.
          state_d = ST_COMMIT;
        end else begin
          // Value change targets the current field before set advances it.
          if (inc_edge ^ dec_edge) begin
            for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
              if (sel_q == SEL_W'(i)) begin
                time_d[8*(NUM_FIELDS-i)-1 -: 8] = inc_edge
                  ? bcd_inc(time_q[8*(NUM_FIELDS-i)-1 -: 8], field_max(i))
                  : bcd_dec(time_q[8*(NUM_FIELDS-i)-1 -: 8], field_max(i));
              end
            end
          end
          if (set_edge) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
          end
          if (action) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
          end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
      end

      ST_COMMIT: begin
        commit  = 1'b1;
        time_d  = cur_time;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; button history resets high so held buttons stay quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      time_q      <= '0;
      sel_q       <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      set_prev_q  <= 1'b1;
      inc_prev_q  <= 1'b1;
      dec_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      sel_q       <= sel_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      set_prev_q  <= set_prev_d;
      inc_prev_q  <= inc_prev_d;
      dec_prev_q  <= dec_prev_d;
    end
  end

  assign time_out  = time_q;
  assign field_sel = sel_q;

endmodule
